// File: rtl/video_out_hmag_pkg.sv
// Shared types and constants for the horizontal magnifier configuration path.
package video_out_hmag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DIVIDE     = 2'd1,
        ST_WAIT_FRAME = 2'd2,
        ST_COMMIT     = 2'd3
    } hmag_ctrl_state_t;

    localparam int NORM_NUMERATOR  = 32768;
    localparam int DIV_STEPS       = 16;
    localparam int DEN_MIN_DEFAULT = 144;
    localparam int DEN_MAX_DEFAULT = 200;
    localparam int OFS_MAX_DEFAULT = 112;

    // Force an 8-bit value into [lo, hi].
    function automatic logic [7:0] clamp_u8(input logic [7:0] value,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/video_out_hmag_div.sv
// Serial restoring divider: NORM_NUMERATOR / divisor, one quotient bit per clk.
module video_out_hmag_div
    import video_out_hmag_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  divisor,
    output logic        done,
    output logic [15:0] quotient
);

    localparam int CNT_W = $clog2(DIV_STEPS + 1);

    logic [7:0]       r_divisor;
    logic [7:0]       r_rem;
    logic [15:0]      r_dvd;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic [8:0]       w_trial;
    logic             w_fits;
    logic [7:0]       w_diff;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_trial = {r_rem, r_dvd[15]};
        w_fits  = w_trial >= {1'b0, r_divisor};
        // The difference fits in 8 bits whenever w_fits holds, because it is below the divisor.
        w_diff  = w_trial[7:0] - r_divisor;
    end

    // Load on start, then retire one quotient bit per clk; quotient bits replace dividend bits.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking <= so all registers update from pre-edge values.
        if (!reset_n) begin
            r_divisor <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else if (start) begin
            r_divisor <= divisor;
            r_rem     <= '0;
            r_dvd     <= 16'(NORM_NUMERATOR);
            r_count   <= CNT_W'(DIV_STEPS);
            r_done    <= 1'b0;
        end else if (r_count != '0) begin
            r_rem   <= w_fits ? w_diff : w_trial[7:0];
            r_dvd   <= {r_dvd[14:0], w_fits};
            r_count <= r_count - 1'b1;
            r_done  <= (r_count == CNT_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign done     = r_done;
    assign quotient = r_dvd;

endmodule

// File: rtl/video_out_hmag_ctrl.sv
// Configuration sequencer for video_out_hmag: clamp, divide, commit atomically at frame end.
module video_out_hmag_ctrl
    import video_out_hmag_pkg::*;
#(
    parameter int H_LAST   = 1367,
    parameter int V_LAST   = 523,
    parameter int DEN_MIN  = DEN_MIN_DEFAULT,
    parameter int DEN_MAX  = DEN_MAX_DEFAULT,
    parameter int OFS_MAX  = OFS_MAX_DEFAULT,
    parameter int DEN_INIT = 180,
    parameter int OFS_INIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [10:0] vdp_hcounter,
    input  logic [10:0] vdp_vcounter,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_immediate,
    input  logic [7:0]  req_left_offset,
    input  logic [7:0]  req_denominator,
    output logic        busy,
    output logic [7:0]  reg_left_offset,
    output logic [7:0]  reg_denominator,
    output logic [7:0]  reg_normalize
);

    localparam logic [10:0] L_H_LAST    = 11'(H_LAST);
    localparam logic [10:0] L_V_LAST    = 11'(V_LAST);
    localparam logic [7:0]  L_DEN_MIN   = 8'(DEN_MIN);
    localparam logic [7:0]  L_DEN_MAX   = 8'(DEN_MAX);
    localparam logic [7:0]  L_OFS_MAX   = 8'(OFS_MAX);
    localparam logic [7:0]  L_DEN_INIT  = 8'(DEN_INIT);
    localparam logic [7:0]  L_OFS_INIT  = 8'(OFS_INIT);
    localparam logic [7:0]  L_NORM_INIT = 8'(NORM_NUMERATOR / DEN_INIT);

    hmag_ctrl_state_t r_state;
    hmag_ctrl_state_t w_next_state;

    logic        w_frame_strobe;
    logic        w_accept;
    logic        w_commit;
    logic [7:0]  w_den_clamp;
    logic [7:0]  w_ofs_clamp;
    logic        w_div_done;
    logic [15:0] w_quotient;
    logic [7:0]  w_norm;

    logic [7:0]  r_shadow_ofs;
    logic [7:0]  r_shadow_den;
    logic [7:0]  r_shadow_norm;
    logic        r_shadow_imm;
    logic [7:0]  r_out_ofs;
    logic [7:0]  r_out_den;
    logic [7:0]  r_out_norm;

    assign w_frame_strobe = enable && (vdp_hcounter == L_H_LAST) && (vdp_vcounter == L_V_LAST);
    assign w_accept       = req_valid && req_ready;
    assign w_den_clamp    = clamp_u8(req_denominator, L_DEN_MIN, L_DEN_MAX);
    assign w_ofs_clamp    = clamp_u8(req_left_offset, 8'd0, L_OFS_MAX);
    // The clamped divisor keeps the upper quotient byte at zero; saturate rather than wrap if it ever is not.
    assign w_norm         = (|w_quotient[15:8]) ? 8'hFF : w_quotient[7:0];

    video_out_hmag_div u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (w_accept),
        .divisor  (w_den_clamp),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic; a strobe seen while still dividing is simply not looked at.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:       if (req_valid) w_next_state = ST_DIVIDE;
            ST_DIVIDE:     if (w_div_done) w_next_state = r_shadow_imm ? ST_COMMIT : ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (w_frame_strobe) w_next_state = ST_COMMIT;
            ST_COMMIT:     w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        w_commit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_COMMIT: w_commit = 1'b1;
            default: ;
        endcase
    end

    // Shadows capture the clamped request and the quotient; outputs load together on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: shadows reset too, so a reset mid-update cannot leak a stale request into a later commit.
        if (!reset_n) begin
            r_shadow_ofs  <= L_OFS_INIT;
            r_shadow_den  <= L_DEN_INIT;
            r_shadow_norm <= L_NORM_INIT;
            r_shadow_imm  <= 1'b0;
            r_out_ofs     <= L_OFS_INIT;
            r_out_den     <= L_DEN_INIT;
            r_out_norm    <= L_NORM_INIT;
        end else begin
            if (w_accept) begin
                r_shadow_ofs <= w_ofs_clamp;
                r_shadow_den <= w_den_clamp;
                r_shadow_imm <= req_immediate;
            end
            if ((r_state == ST_DIVIDE) && w_div_done) begin
                r_shadow_norm <= w_norm;
            end
            if (w_commit) begin
                r_out_ofs  <= r_shadow_ofs;
                r_out_den  <= r_shadow_den;
                r_out_norm <= r_shadow_norm;
            end
        end
    end

    assign reg_left_offset = r_out_ofs;
    assign reg_denominator = r_out_den;
    assign reg_normalize   = r_out_norm;

endmodule
